// File: rtl/sr_frame_reader.sv
// sr_frame_reader: pops the SR output FIFO, aligns on frame_sync toggles and
// emits x/y-tagged RGB565 pixels through a 2-entry skid buffer.
module sr_frame_reader #(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int RD_THRESH = 2
) (
  input  logic        clk_r,
  input  logic        rst_n,
  input  logic [16:0] fifo_dout,
  input  logic [9:0]  data_count_r,
  output logic        rd_fifo,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [15:0] pix_data,
  output logic [9:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic        sof,
  output logic        eol,
  output logic        sync_err,
  output logic [7:0]  err_count
);
  typedef enum logic {SYNC, STREAM} state_t;
  localparam logic [9:0] XL = 10'(H_ACTIVE - 1);
  localparam logic [8:0] YL = 9'(V_ACTIVE - 1);
  state_t      state_q, state_d;
  logic        ref_q, ref_d, refv_q, refv_d, inflight_q, err_q, err_d;
  logic        push, pop, s, at_origin;
  logic [9:0]  x_q, x_d, tx;
  logic [8:0]  y_q, y_d, ty;
  logic [1:0]  cnt_q;
  logic        rp_q, wp_q;
  logic [7:0]  errc_q;
  logic [34:0] mem_q [2];
  logic [34:0] head;
  assign s         = fifo_dout[16];
  assign at_origin = (x_q == '0) && (y_q == '0);
  assign pix_valid = cnt_q != 2'd0;
  assign pop       = pix_valid && pix_ready;
  // Count words already in the buffer or in flight so a new read can never overflow it.
  assign rd_fifo   = rst_n && (data_count_r >= 10'(RD_THRESH)) &&
                     (({1'b0, cnt_q} + {2'b0, inflight_q} - {2'b0, pop}) < 3'd2);
  assign head      = mem_q[rp_q];
  assign pix_data  = head[34:19];
  assign pix_x     = head[18:9];
  assign pix_y     = head[8:0];
  assign sof       = pix_valid && (pix_x == '0) && (pix_y == '0);
  assign eol       = pix_valid && (pix_x == XL);
  assign sync_err  = err_q;
  assign err_count = errc_q;
  always_comb begin
    state_d = state_q;
    ref_d   = ref_q;
    refv_d  = refv_q;
    x_d     = x_q;
    y_d     = y_q;
    tx      = x_q;
    ty      = y_q;
    push    = 1'b0;
    err_d   = 1'b0;
    if (inflight_q) begin
      if (state_q == SYNC) begin
        ref_d  = s;
        refv_d = 1'b1;
        if (refv_q && s != ref_q) begin
          push    = 1'b1;
          tx      = '0;
          ty      = '0;
          state_d = STREAM;
        end
      end else if (at_origin && s == ref_q) begin
        err_d   = 1'b1;
        state_d = SYNC;
      end else begin
        push  = 1'b1;
        ref_d = s;
        // Early toggle: this word starts a new frame.
        if (s != ref_q && !at_origin) begin
          err_d = 1'b1;
          tx    = '0;
          ty    = '0;
        end
      end
      if (push) begin
        x_d = (tx == XL) ? '0 : tx + 10'd1;
        y_d = (tx == XL) ? ((ty == YL) ? '0 : ty + 9'd1) : ty;
      end
    end
  end
  always_ff @(posedge clk_r or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SYNC;
      ref_q      <= 1'b0;
      refv_q     <= 1'b0;
      inflight_q <= 1'b0;
      err_q      <= 1'b0;
      errc_q     <= '0;
      x_q        <= '0;
      y_q        <= '0;
      cnt_q      <= '0;
      rp_q       <= 1'b0;
      wp_q       <= 1'b0;
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
    end else begin
      state_q    <= state_d;
      ref_q      <= ref_d;
      refv_q     <= refv_d;
      inflight_q <= rd_fifo;
      err_q      <= err_d;
      x_q        <= x_d;
      y_q        <= y_d;
      if (err_d && errc_q != 8'hff) errc_q <= errc_q + 8'd1;
      if (push) begin
        mem_q[wp_q] <= {fifo_dout[15:0], tx, ty};
        wp_q        <= ~wp_q;
      end
      if (pop) rp_q <= ~rp_q;
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule

// File: tb/tb_sr_frame_reader.sv
// tb_sr_frame_reader: directed checks of sr_frame_reader on a small 8x4 frame
// against a FIFO model and a scoreboard of hand-built expected pixels.
`define CHK(t, o, e) begin n_cmp++; assert ((o) === (e)) else begin n_bad++; $error("FAIL %s: observed=%0h expected=%0h", t, o, e); end end
module tb_sr_frame_reader;
  localparam int H = 8;
  localparam int V = 4;
  logic        clk_r = 1'b0, rst_n = 1'b0, pix_ready = 1'b1;
  logic [16:0] fifo_dout = '0;
  logic [9:0]  data_count_r;
  logic        rd_fifo, pix_valid, sof, eol, sync_err;
  logic [15:0] pix_data;
  logic [9:0]  pix_x;
  logic [8:0]  pix_y;
  logic [7:0]  err_count;
  logic [16:0] fmem [4096];
  logic [36:0] emem [4096];
  int          wi = 0, ri = 0, ewi = 0, eri = 0, n_cmp = 0, n_bad = 0, err_pulses = 0;
  logic        flush = 1'b0, ovr_en = 1'b0, chk_en = 1'b1;
  logic [9:0]  ovr_val = '0;
  always #5 clk_r = ~clk_r;
  sr_frame_reader #(.H_ACTIVE(H), .V_ACTIVE(V), .RD_THRESH(2)) dut (
    .clk_r(clk_r), .rst_n(rst_n), .fifo_dout(fifo_dout), .data_count_r(data_count_r),
    .rd_fifo(rd_fifo), .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .pix_x(pix_x), .pix_y(pix_y), .sof(sof), .eol(eol), .sync_err(sync_err),
    .err_count(err_count)
  );
  // Writer-side FIFO model: data valid one cycle after rd_fifo.
  assign data_count_r = ovr_en ? ovr_val : 10'(wi - ri);
  always @(posedge clk_r) begin
    if (flush) ri <= wi;
    else if (rd_fifo && ri != wi) begin
      fifo_dout <= fmem[ri];
      ri        <= ri + 1;
    end
  end
  task automatic push_w(input logic sb, input logic [15:0] p);
    fmem[wi] = {sb, p};
    wi++;
  endtask
  task automatic exp_px(input logic [15:0] p, input int x, input int y);
    emem[ewi] = {p, 10'(x), 9'(y), (x == 0 && y == 0), (x == H - 1)};
    ewi++;
  endtask
  task automatic push_frame(input logic sb, input int base, input bit expect_it);
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++) begin
        push_w(sb, 16'(base + y * H + x));
        if (expect_it) exp_px(16'(base + y * H + x), x, y);
      end
  endtask
  task automatic wait_drain(input string t, input int lim);
    for (int i = 0; i < lim && eri != ewi; i++) begin
      @(negedge clk_r);
      #2;
    end
    `CHK(t, eri, ewi)
  endtask
  task automatic do_reset();
    @(negedge clk_r);
    rst_n = 1'b0;
    flush = 1'b1;
    @(posedge clk_r);
    #1 flush = 1'b0;
    @(negedge clk_r);
    rst_n = 1'b1;
  endtask
  // Output monitor: scoreboard on accepted pixels, stability while stalled.
  initial begin
    logic        prev_stall;
    logic [41:0] prev_snap;
    prev_stall = 1'b0;
    prev_snap  = '0;
    forever begin
      @(negedge clk_r);
      #1;
      if (!rst_n) prev_stall = 1'b0;
      else begin
        if (prev_stall) `CHK("hold", {pix_valid, pix_data, pix_x, pix_y, sof, eol}, prev_snap)
        if (chk_en && pix_valid && pix_ready) begin
          `CHK("exp_avail", (ewi - eri) > 0, 1'b1)
          if (ewi > eri) begin
            `CHK("pixel", {pix_data, pix_x, pix_y, sof, eol}, emem[eri])
            eri++;
          end
        end
        prev_stall = pix_valid && !pix_ready;
        prev_snap  = {pix_valid, pix_data, pix_x, pix_y, sof, eol};
        if (sync_err) err_pulses++;
      end
    end
  end
  initial begin
    int  e0;
    logic rd_seen;
    // Basic: frame s=0 dropped, frames s=1 and s=0 streamed.
    push_frame(1'b0, 'h000, 1'b0);
    push_frame(1'b1, 'h100, 1'b1);
    push_frame(1'b0, 'h200, 1'b1);
    push_w(1'b1, 16'hFFFF);
    repeat (2) @(negedge clk_r);
    `CHK("rst_rd", rd_fifo, 1'b0)
    `CHK("rst_valid", pix_valid, 1'b0)
    `CHK("rst_data", {pix_data, pix_x, pix_y, sof, eol}, 37'd0)
    `CHK("rst_err", {sync_err, err_count}, 9'd0)
    rst_n = 1'b1;
    wait_drain("drain_basic", 400);
    `CHK("basic_err_count", err_count, 8'd0)
    `CHK("basic_err_pulses", err_pulses, 0)
    `CHK("basic_count", eri, 64)
    // Random backpressure through a full frame.
    do_reset();
    push_w(1'b0, 16'h0AAA);
    push_frame(1'b1, 'h300, 1'b1);
    push_w(1'b0, 16'hFFFF);
    for (int i = 0; i < 1000 && eri != ewi; i++) begin
      @(negedge clk_r);
      pix_ready = 1'($urandom_range(0, 1));
    end
    @(negedge clk_r);
    pix_ready = 1'b1;
    wait_drain("drain_random", 50);
    // Read threshold and first-pixel latency.
    do_reset();
    push_w(1'b0, 16'h0AAA);
    for (int i = 0; i < 4; i++) push_w(1'b1, 16'h400 + 16'(i));
    for (int i = 0; i < 3; i++) exp_px(16'h400 + 16'(i), i, 0);
    wait_drain("drain_thr", 100);
    repeat (3) @(negedge clk_r);
    `CHK("below_thresh_rd", rd_fifo, 1'b0)
    ovr_en  = 1'b1;
    ovr_val = 10'd1;
    for (int i = 4; i < 8; i++) push_w(1'b1, 16'h400 + 16'(i));
    for (int i = 3; i < 7; i++) exp_px(16'h400 + 16'(i), i, 0);
    rd_seen = 1'b0;
    repeat (8) begin
      @(negedge clk_r);
      rd_seen |= rd_fifo;
    end
    `CHK("cnt1_no_rd", rd_seen, 1'b0)
    @(negedge clk_r);
    ovr_val = 10'd5;
    #1 `CHK("rd_at_5", rd_fifo, 1'b1)
    @(negedge clk_r);
    `CHK("lat_n1_valid", pix_valid, 1'b0)
    ovr_en = 1'b0;
    @(negedge clk_r);
    `CHK("lat_n2_valid", pix_valid, 1'b1)
    `CHK("lat_n2_data", pix_data, 16'h0403)
    wait_drain("drain_lat", 100);
    // Early toggle at (5,2).
    do_reset();
    e0 = err_pulses;
    push_w(1'b0, 16'h0AAA);
    for (int k = 0; k < 21; k++) begin
      push_w(1'b1, 16'h500 + 16'(k));
      exp_px(16'h500 + 16'(k), k % H, k / H);
    end
    for (int k = 0; k < 11; k++) begin
      push_w(1'b0, 16'h600 + 16'(k));
      exp_px(16'h600 + 16'(k), k % H, k / H);
    end
    push_w(1'b0, 16'hFFFF);
    wait_drain("drain_early", 200);
    `CHK("early_err_count", err_count, 8'd1)
    `CHK("early_err_pulses", err_pulses - e0, 1)
    // Long frame: 5 extra words dropped, resume at next toggle.
    do_reset();
    e0 = err_pulses;
    push_w(1'b0, 16'h0AAA);
    push_frame(1'b1, 'h700, 1'b1);
    for (int k = 0; k < 5; k++) push_w(1'b1, 16'h7E0 + 16'(k));
    push_frame(1'b0, 'h800, 1'b1);
    push_w(1'b1, 16'h900);
    wait_drain("drain_long", 300);
    `CHK("long_err_count", err_count, 8'd1)
    `CHK("long_err_pulses", err_pulses - e0, 1)
    // Alternating sync bits: every word after the first is an early toggle.
    for (int k = 1; k < 300; k++) push_w((k % 2) == 0, 16'h900 + 16'(k));
    for (int k = 0; k < 300; k++) exp_px(16'h900 + 16'(k), 0, 0);
    push_w(1'b1, 16'hFFFF);
    wait_drain("drain_sat", 2000);
    `CHK("sat_err_count", err_count, 8'd255)
    `CHK("sat_err_pulses", err_pulses - e0, 300)
    // Asynchronous reset mid-line.
    do_reset();
    chk_en = 1'b0;
    push_w(1'b0, 16'h0AAA);
    for (int k = 0; k < 20; k++) push_w(1'b1, 16'hA00 + 16'(k));
    repeat (8) @(negedge clk_r);
    @(posedge clk_r);
    #3;
    `CHK("pre_rst_rd", rd_fifo, 1'b1)
    `CHK("pre_rst_valid", pix_valid, 1'b1)
    rst_n = 1'b0;
    #1;
    `CHK("async_rd", rd_fifo, 1'b0)
    `CHK("async_valid", pix_valid, 1'b0)
    `CHK("async_out", {pix_data, pix_x, pix_y, sof, eol, sync_err, err_count}, 46'd0)
    flush = 1'b1;
    @(posedge clk_r);
    #1 flush = 1'b0;
    @(negedge clk_r);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    for (int k = 0; k < 4; k++) push_w(1'b1, 16'hB00 + 16'(k));
    for (int k = 0; k < 10; k++) begin
      push_w(1'b0, 16'hC00 + 16'(k));
      exp_px(16'hC00 + 16'(k), k % H, k / H);
    end
    push_w(1'b0, 16'hFFFF);
    wait_drain("drain_rst", 200);
    `CHK("rst_err_count", err_count, 8'd0)
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
